// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer driving a shared 32-bit ALU,
// owning the architectural HI/LO registers and the MTHI/MTLO write path.
module muldiv_seq #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              flush,
  input  logic              mt_hi,
  input  logic              mt_lo,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result
);

  localparam int unsigned     W2        = 2 * DATA_W;
  localparam logic [3:0]      ALU_ADD   = 4'b0010;
  localparam logic [3:0]      ALU_SUB   = 4'b0110;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_STEP,
    S_FIX,
    S_DONE
  } state_t;

  state_t              state;
  logic                is_div;
  logic                neg_q;
  logic                neg_r;
  logic                div_zero;
  logic [DATA_W-1:0]   mag_rs;
  logic [DATA_W-1:0]   mag_rt;
  logic [DATA_W-1:0]   raw_rs;
  logic [DATA_W-1:0]   sh_hi;
  logic [DATA_W-1:0]   sh_lo;
  logic [CNT_W-1:0]    cnt;

  logic                sgn_op;
  logic [DATA_W-1:0]   abs_rs;
  logic [DATA_W-1:0]   abs_rt;
  logic [DATA_W:0]     sh;
  logic                carry;
  logic                sub_ok;
  logic [W2-1:0]       prod_neg;
  logic [DATA_W-1:0]   hi_neg;
  logic [DATA_W-1:0]   lo_neg;

  // Operand magnitudes; 0x80000000 stays as-is and is treated as unsigned.
  always_comb begin
    sgn_op = ~op[0];
    abs_rs = (sgn_op && rs_val[DATA_W-1]) ? (~rs_val + DATA_W'(1)) : rs_val;
    abs_rt = (sgn_op && rt_val[DATA_W-1]) ? (~rt_val + DATA_W'(1)) : rt_val;
  end

  // Step datapath helpers and sign-fix values.
  always_comb begin
    sh       = {hi, lo[DATA_W-1]};
    carry    = (alu_result < hi);
    sub_ok   = sh[DATA_W] | (sh[DATA_W-1:0] >= mag_rt);
    prod_neg = ~{hi, lo} + W2'(1);
    hi_neg   = ~hi + DATA_W'(1);
    lo_neg   = ~lo + DATA_W'(1);
  end

  // ALU drive: add for shift-add multiply, subtract for restoring divide.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = ALU_ADD;
    if (state == S_STEP) begin
      if (is_div) begin
        alu_a    = sh[DATA_W-1:0];
        alu_b    = mag_rt;
        alu_ctrl = ALU_SUB;
      end else begin
        alu_a = hi;
        alu_b = lo[0] ? mag_rs : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      mag_rs   <= '0;
      mag_rt   <= '0;
      raw_rs   <= '0;
      sh_hi    <= '0;
      sh_lo    <= '0;
    end else begin
      done <= 1'b0;
      if (flush && busy) begin
        // Abort: restore the architectural values saved at accept.
        state <= S_IDLE;
        busy  <= 1'b0;
        hi    <= sh_hi;
        lo    <= sh_lo;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              state    <= S_PREP;
              busy     <= 1'b1;
              is_div   <= op[1];
              neg_q    <= sgn_op & (rs_val[DATA_W-1] ^ rt_val[DATA_W-1]);
              neg_r    <= sgn_op & rs_val[DATA_W-1];
              div_zero <= (rt_val == '0);
              mag_rs   <= abs_rs;
              mag_rt   <= abs_rt;
              raw_rs   <= rs_val;
              sh_hi    <= hi;
              sh_lo    <= lo;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
              if (mt_hi) hi <= wdata;
              if (mt_lo) lo <= wdata;
            end
          end
          S_PREP: begin
            hi    <= '0;
            lo    <= is_div ? mag_rs : mag_rt;
            cnt   <= '0;
            state <= S_STEP;
          end
          S_STEP: begin
            if (is_div) begin
              if (sub_ok) begin
                hi <= alu_result;
                lo <= {lo[DATA_W-2:0], 1'b1};
              end else begin
                hi <= sh[DATA_W-1:0];
                lo <= {lo[DATA_W-2:0], 1'b0};
              end
            end else begin
              hi <= {carry, alu_result[DATA_W-1:1]};
              lo <= {alu_result[0], lo[DATA_W-1:1]};
            end
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_STEP) state <= S_FIX;
          end
          S_FIX: begin
            if (is_div) begin
              if (div_zero) begin
                hi <= raw_rs;
                lo <= '1;
              end else begin
                if (neg_r) hi <= hi_neg;
                if (neg_q) lo <= lo_neg;
              end
            end else if (neg_q) begin
              hi <= prod_neg[W2-1:DATA_W];
              lo <= prod_neg[DATA_W-1:0];
            end
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
